// File: rtl/agc_decode_pkg.sv
// Shared types for the AGC instruction decode sequencer.
// Op codes, address regions and default memory-map boundaries.
package agc_decode_pkg;

    localparam int REG_TOP_D  = 13;
    localparam int ROM_BASE_D = 'o2000;

    typedef enum logic [5:0] {
        OP_NOP, OP_TC, OP_RETURN, OP_EXTEND, OP_TCF,
        OP_DAS, OP_LXCH, OP_INCR, OP_ADS, OP_CA,
        OP_COM, OP_CS, OP_INDEX, OP_DXCH, OP_TS,
        OP_XCH, OP_AD, OP_MASK, OP_READ, OP_WRITE,
        OP_RAND, OP_WAND, OP_ROR, OP_WOR, OP_RXOR,
        OP_BZF, OP_DV, OP_QXCH, OP_AUG, OP_DIM,
        OP_DCA, OP_DCS, OP_SU, OP_BZMF, OP_MP
    } op_e;

    typedef enum logic [1:0] {
        RGN_REG, RGN_RAM, RGN_ROM
    } region_e;

    typedef enum logic {
        S_NORMAL, S_IDX_WAIT
    } state_e;

endpackage

// File: rtl/agc_decode_seq_if.sv
// Fetch, INDEX operand and decode-to-execute signals.
// master drives the sequencer inputs, slave is the sequencer.
interface agc_decode_seq_if
    import agc_decode_pkg::*;
#(
    parameter int WORD_W = 15,
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_instr;
    logic              idx_req;
    logic [ADDR_W-1:0] idx_addr;
    logic              idx_valid;
    logic [WORD_W-1:0] idx_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    op_e               out_op;
    logic              out_extra;
    region_e           out_region;
    logic              out_illegal;
    logic              flush;

    modport master (
        output in_valid, in_instr, idx_valid, idx_data,
        output out_ready, flush,
        input  in_ready, idx_req, idx_addr, out_valid,
        input  out_instr, out_op, out_extra, out_region,
        input  out_illegal
    );

    modport slave (
        input  in_valid, in_instr, idx_valid, idx_data,
        input  out_ready, flush,
        output in_ready, idx_req, idx_addr, out_valid,
        output out_instr, out_op, out_extra, out_region,
        output out_illegal
    );
endinterface

// File: rtl/agc_op_lookup.sv
// Combinational opcode table: effective word plus extracode
// flag in, decoded op, illegal flag and address region out.
module agc_op_lookup
    import agc_decode_pkg::*;
#(
    parameter int WORD_W   = 15,
    parameter int ADDR_W   = 12,
    parameter int REG_TOP  = REG_TOP_D,
    parameter int ROM_BASE = ROM_BASE_D
) (
    input  logic [WORD_W-1:0] eff,
    input  logic              ext,
    output op_e               op,
    output logic              illegal,
    output region_e           region
);
    localparam logic [ADDR_W-1:0] REG_A = ADDR_W'(REG_TOP);
    localparam logic [ADDR_W-1:0] ROM_A = ADDR_W'(ROM_BASE);

    logic [2:0]        opc;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        q;
    logic [2:0]        sel;
    logic              rom;

    assign opc  = eff[WORD_W-1 -: 3];
    assign addr = eff[ADDR_W-1:0];
    assign q    = addr[ADDR_W-1 -: 2];
    assign sel  = addr[ADDR_W-1 -: 3];
    assign rom  = (addr >= ROM_A);

    always_comb begin
        region = RGN_ROM;
        unique case (1'b1)
            (addr < REG_A):           region = RGN_REG;
            (addr >= REG_A) && !rom:  region = RGN_RAM;
            default:                  region = RGN_ROM;
        endcase
    end

    always_comb begin
        op      = OP_NOP;
        illegal = 1'b0;
        if (!ext) begin
            unique case (opc)
                3'd0: begin
                    unique case (eff[2:0])
                        3'd2:    op = OP_RETURN;
                        3'd6:    op = OP_EXTEND;
                        default: op = OP_TC;
                    endcase
                end
                3'd1: op = OP_TCF;
                3'd2: begin
                    unique case (q)
                        2'd0: op = OP_DAS;
                        2'd1: op = OP_LXCH;
                        2'd2: op = OP_INCR;
                        2'd3: op = OP_ADS;
                    endcase
                end
                3'd3: op = OP_CA;
                3'd4: op = (addr == '0) ? OP_COM : OP_CS;
                3'd5: begin
                    unique case (q)
                        2'd0: op = OP_INDEX;
                        2'd1: op = OP_DXCH;
                        2'd2: op = OP_TS;
                        2'd3: op = OP_XCH;
                    endcase
                end
                3'd6: op = OP_AD;
                3'd7: op = OP_MASK;
            endcase
        end else begin
            unique case (opc)
                3'd0: begin
                    unique case (sel)
                        3'd0: op = OP_READ;
                        3'd1: op = OP_WRITE;
                        3'd2: op = OP_RAND;
                        3'd3: op = OP_WAND;
                        3'd4: op = OP_ROR;
                        3'd5: op = OP_WOR;
                        3'd6: op = OP_RXOR;
                        3'd7: illegal = 1'b1;
                    endcase
                end
                3'd1: op = rom ? OP_BZF : OP_DV;
                3'd2: begin
                    unique case (q)
                        2'd0: illegal = 1'b1;
                        2'd1: op = OP_QXCH;
                        2'd2: op = OP_AUG;
                        2'd3: op = OP_DIM;
                    endcase
                end
                3'd3: op = OP_DCA;
                3'd4: op = OP_DCS;
                3'd5: op = OP_INDEX;
                3'd6: op = rom ? OP_BZMF : OP_SU;
                3'd7: op = OP_MP;
            endcase
        end
    end
endmodule

// File: rtl/agc_decode_seq.sv
// AGC decode sequencer: folds EXTEND and INDEX prefixes into
// the following word and hands decoded ops to execute.
module agc_decode_seq
    import agc_decode_pkg::*;
#(
    parameter int WORD_W   = 15,
    parameter int ADDR_W   = 12,
    parameter int REG_TOP  = REG_TOP_D,
    parameter int ROM_BASE = ROM_BASE_D
) (
    input logic             clock,
    input logic             rst_l,
    agc_decode_seq_if.slave bus
);
    state_e            state, state_nx;
    logic              ext, idx_pend, idx_req_q;
    logic [WORD_W-1:0] idx_val, eff;
    op_e               lk_op;
    logic              lk_ill;
    region_e           lk_rgn;
    logic              accept, is_ext, is_idx;

    assign eff    = idx_pend ? bus.in_instr + idx_val
                             : bus.in_instr;
    assign accept = bus.in_valid && bus.in_ready;
    assign is_ext = (lk_op == OP_EXTEND);
    assign is_idx = (lk_op == OP_INDEX);

    agc_op_lookup #(
        .WORD_W  (WORD_W),
        .ADDR_W  (ADDR_W),
        .REG_TOP (REG_TOP),
        .ROM_BASE(ROM_BASE)
    ) u_lookup (
        .eff    (eff),
        .ext    (ext),
        .op     (lk_op),
        .illegal(lk_ill),
        .region (lk_rgn)
    );

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) state <= S_NORMAL;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = S_NORMAL;
        end else begin
            unique case (state)
                S_NORMAL:
                    if (accept && is_idx) state_nx = S_IDX_WAIT;
                S_IDX_WAIT:
                    if (bus.idx_valid) state_nx = S_NORMAL;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = !bus.flush && (state == S_NORMAL)
                     && (!bus.out_valid || bus.out_ready);
        bus.idx_req  = idx_req_q && !bus.flush;
    end

    // Prefix state and output register; flush overrides everything.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            ext             <= 1'b0;
            idx_pend        <= 1'b0;
            idx_val         <= '0;
            idx_req_q       <= 1'b0;
            bus.idx_addr    <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_instr   <= '0;
            bus.out_op      <= OP_NOP;
            bus.out_extra   <= 1'b0;
            bus.out_region  <= RGN_REG;
            bus.out_illegal <= 1'b0;
        end else if (bus.flush) begin
            ext           <= 1'b0;
            idx_pend      <= 1'b0;
            idx_req_q     <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            idx_req_q <= 1'b0;
            if (state == S_IDX_WAIT && bus.idx_valid) begin
                idx_val  <= bus.idx_data;
                idx_pend <= 1'b1;
            end
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            if (accept) begin
                if (is_ext) begin
                    ext      <= 1'b1;
                    idx_pend <= 1'b0;
                end else if (is_idx) begin
                    idx_req_q    <= 1'b1;
                    bus.idx_addr <= eff[ADDR_W-1:0];
                    idx_pend     <= 1'b0;
                end else begin
                    bus.out_valid   <= 1'b1;
                    bus.out_instr   <= eff;
                    bus.out_op      <= lk_ill ? OP_NOP : lk_op;
                    bus.out_extra   <= ext;
                    bus.out_region  <= lk_rgn;
                    bus.out_illegal <= lk_ill;
                    ext             <= 1'b0;
                    idx_pend        <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_agc_decode_seq.sv
// Bench for agc_decode_seq: opcode table vectors through a
// scoreboard plus hand sequences for prefixes, stall, flush.
module tb_agc_decode_seq;
    import agc_decode_pkg::*;

    typedef struct {
        logic [14:0] instr;
        op_e         op;
        logic        extra;
        region_e     rgn;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        ext;
        logic [14:0] w;
        op_e         op;
        region_e     rgn;
        logic        ill;
    } vec_t;

    logic clk, rst_l;
    int   errs, checks;
    exp_t sb[$];
    vec_t vt[34];

    agc_decode_seq_if #(.WORD_W(15), .ADDR_W(12)) ifc ();

    agc_decode_seq dut (
        .clock(clk),
        .rst_l(rst_l),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_l && ifc.out_valid && ifc.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL stray_output: instr=%o op=%0d",
                         ifc.out_instr, ifc.out_op);
            end else begin
                e = sb.pop_front();
                if (ifc.out_instr !== e.instr || ifc.out_op !== e.op
                    || ifc.out_extra !== e.extra
                    || ifc.out_region !== e.rgn
                    || ifc.out_illegal !== e.ill) begin
                    errs++;
                    $display("FAIL output: got %o/%0d/x%b/r%0d/i%b want %o/%0d/x%b/r%0d/i%b",
                             ifc.out_instr, ifc.out_op, ifc.out_extra,
                             ifc.out_region, ifc.out_illegal,
                             e.instr, e.op, e.extra, e.rgn, e.ill);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [14:0] i, input op_e op,
                        input logic x, input region_e r,
                        input logic il);
        exp_t e;
        e.instr = i; e.op = op; e.extra = x; e.rgn = r; e.ill = il;
        sb.push_back(e);
    endtask

    task automatic send(input logic [14:0] w);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_instr = w;
        @(negedge clk);
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: word %o not accepted", w);
        end
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
    endtask

    task automatic idx_pulse(input logic [14:0] d);
        ifc.idx_valid = 1'b1;
        ifc.idx_data  = d;
        @(posedge clk);
        #1 ifc.idx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: %0d outputs missing",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 15'o030200, OP_CA,     RGN_RAM, 1'b0};
        vt[1]  = '{1'b0, 15'o012000, OP_TCF,    RGN_ROM, 1'b0};
        vt[2]  = '{1'b0, 15'o000002, OP_RETURN, RGN_REG, 1'b0};
        vt[3]  = '{1'b0, 15'o001777, OP_TC,     RGN_RAM, 1'b0};
        vt[4]  = '{1'b0, 15'o040000, OP_COM,    RGN_REG, 1'b0};
        vt[5]  = '{1'b0, 15'o040100, OP_CS,     RGN_RAM, 1'b0};
        vt[6]  = '{1'b0, 15'o020000, OP_DAS,    RGN_REG, 1'b0};
        vt[7]  = '{1'b0, 15'o022000, OP_LXCH,   RGN_ROM, 1'b0};
        vt[8]  = '{1'b0, 15'o024000, OP_INCR,   RGN_ROM, 1'b0};
        vt[9]  = '{1'b0, 15'o026000, OP_ADS,    RGN_ROM, 1'b0};
        vt[10] = '{1'b0, 15'o052000, OP_DXCH,   RGN_ROM, 1'b0};
        vt[11] = '{1'b0, 15'o054000, OP_TS,     RGN_ROM, 1'b0};
        vt[12] = '{1'b0, 15'o056000, OP_XCH,    RGN_ROM, 1'b0};
        vt[13] = '{1'b0, 15'o060015, OP_AD,     RGN_RAM, 1'b0};
        vt[14] = '{1'b0, 15'o070014, OP_MASK,   RGN_REG, 1'b0};
        vt[15] = '{1'b1, 15'o000000, OP_READ,   RGN_REG, 1'b0};
        vt[16] = '{1'b1, 15'o001000, OP_WRITE,  RGN_RAM, 1'b0};
        vt[17] = '{1'b1, 15'o002000, OP_RAND,   RGN_ROM, 1'b0};
        vt[18] = '{1'b1, 15'o003000, OP_WAND,   RGN_ROM, 1'b0};
        vt[19] = '{1'b1, 15'o004000, OP_ROR,    RGN_ROM, 1'b0};
        vt[20] = '{1'b1, 15'o005000, OP_WOR,    RGN_ROM, 1'b0};
        vt[21] = '{1'b1, 15'o006000, OP_RXOR,   RGN_ROM, 1'b0};
        vt[22] = '{1'b1, 15'o007000, OP_NOP,    RGN_ROM, 1'b1};
        vt[23] = '{1'b1, 15'o012000, OP_BZF,    RGN_ROM, 1'b0};
        vt[24] = '{1'b1, 15'o011000, OP_DV,     RGN_RAM, 1'b0};
        vt[25] = '{1'b1, 15'o020000, OP_NOP,    RGN_REG, 1'b1};
        vt[26] = '{1'b1, 15'o022000, OP_QXCH,   RGN_ROM, 1'b0};
        vt[27] = '{1'b1, 15'o024000, OP_AUG,    RGN_ROM, 1'b0};
        vt[28] = '{1'b1, 15'o026000, OP_DIM,    RGN_ROM, 1'b0};
        vt[29] = '{1'b1, 15'o030100, OP_DCA,    RGN_RAM, 1'b0};
        vt[30] = '{1'b1, 15'o040100, OP_DCS,    RGN_RAM, 1'b0};
        vt[31] = '{1'b1, 15'o062000, OP_BZMF,   RGN_ROM, 1'b0};
        vt[32] = '{1'b1, 15'o061000, OP_SU,     RGN_RAM, 1'b0};
        vt[33] = '{1'b1, 15'o070000, OP_MP,     RGN_REG, 1'b0};

        errs = 0;
        checks = 0;
        rst_l = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_instr  = '0;
        ifc.idx_valid = 1'b0;
        ifc.idx_data  = '0;
        ifc.out_ready = 1'b1;
        ifc.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_in_ready", 32'(ifc.in_ready), 1);
        chk("rst_idx_req", 32'(ifc.idx_req), 0);
        chk("rst_out_op", 32'(ifc.out_op), 32'(OP_NOP));
        chk("rst_out_instr", 32'(ifc.out_instr), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 34; i++) begin
            if (vt[i].ext) send(15'o000006);
            push(vt[i].w, vt[i].op, vt[i].ext, vt[i].rgn, vt[i].ill);
            send(vt[i].w);
        end
        drain();

        // EXTEND applies to exactly one following word
        send(15'o000006);
        push(15'o012000, OP_BZF, 1'b1, RGN_ROM, 1'b0);
        send(15'o012000);
        push(15'o012000, OP_TCF, 1'b0, RGN_ROM, 1'b0);
        send(15'o012000);
        drain();

        send(15'o050100);
        @(negedge clk);
        chk("idx_req_on", 32'(ifc.idx_req), 1);
        chk("idx_addr", 32'(ifc.idx_addr), 32'o100);
        chk("idx_wait_ready", 32'(ifc.in_ready), 0);
        @(negedge clk);
        chk("idx_req_off", 32'(ifc.idx_req), 0);
        @(posedge clk);
        #1 idx_pulse(15'o5);
        push(15'o030205, OP_CA, 1'b0, RGN_RAM, 1'b0);
        send(15'o030200);
        drain();

        // EXTEND survives an intervening INDEX
        send(15'o000006);
        send(15'o050100);
        @(posedge clk);
        #1 idx_pulse(15'o0);
        push(15'o070300, OP_MP, 1'b1, RGN_RAM, 1'b0);
        send(15'o070300);
        drain();

        ifc.out_ready = 1'b0;
        push(15'o030200, OP_CA, 1'b0, RGN_RAM, 1'b0);
        send(15'o030200);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(ifc.out_valid), 1);
            chk("stall_ready", 32'(ifc.in_ready), 0);
            chk("stall_instr", 32'(ifc.out_instr), 32'o030200);
            chk("stall_op", 32'(ifc.out_op), 32'(OP_CA));
        end
        @(posedge clk);
        #1 ifc.out_ready = 1'b1;
        drain();

        // flush during IDX_WAIT drops the pending index
        send(15'o050100);
        ifc.flush     = 1'b1;
        ifc.idx_valid = 1'b1;
        ifc.idx_data  = 15'o7;
        @(negedge clk);
        chk("flush_idx_req", 32'(ifc.idx_req), 0);
        chk("flush_ready", 32'(ifc.in_ready), 0);
        @(posedge clk);
        #1;
        ifc.flush     = 1'b0;
        ifc.idx_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_ready", 32'(ifc.in_ready), 1);
        @(posedge clk);
        #1;
        push(15'o030200, OP_CA, 1'b0, RGN_RAM, 1'b0);
        send(15'o030200);
        drain();

        send(15'o000006);
        push(15'o007000, OP_NOP, 1'b1, RGN_ROM, 1'b1);
        send(15'o007000);
        push(15'o030200, OP_CA, 1'b0, RGN_RAM, 1'b0);
        send(15'o030200);
        drain();

        // reset in the middle of an INDEX wait
        send(15'o000006);
        send(15'o050100);
        rst_l = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_l = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(ifc.out_valid), 0);
        chk("mid_rst_ready", 32'(ifc.in_ready), 1);
        chk("mid_rst_idx_req", 32'(ifc.idx_req), 0);
        @(posedge clk);
        #1 idx_pulse(15'o3);
        push(15'o030200, OP_CA, 1'b0, RGN_RAM, 1'b0);
        send(15'o030200);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
